// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared encodings for the EX-stage RV32M multiply/divide unit.
// Holds funct3 op codes, FSM state encoding and the default operand width.
package ex_muldiv_pkg;

  localparam int MD_XLEN = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_DIV   = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage request/result bundle for the M-extension unit.
// master = pipeline (req, op, rs1, rs2); slave = unit (stall, valid, result).
interface ex_muldiv_if
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
);
  logic            md_req;
  logic [2:0]      md_op;
  logic [XLEN-1:0] md_rs1;
  logic [XLEN-1:0] md_rs2;
  logic            exe_stall;
  logic            md_result_valid;
  logic [XLEN-1:0] md_result;

  modport master (
    output md_req, md_op, md_rs1, md_rs2,
    input  exe_stall, md_result_valid, md_result
  );

  modport slave (
    input  md_req, md_op, md_rs1, md_rs2,
    output exe_stall, md_result_valid, md_result
  );
endinterface

// File: rtl/ex_muldiv_div_step.sv
// md_div_step: combinational restoring-divide step, DIV_BITS quotient bits.
// In: rem_i, quo_i (dividend shifts out MSB first), dvs_i. Out: rem_o, quo_o.
module md_div_step #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
)(
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   r;
  logic [XLEN-1:0] q;
  logic [XLEN+1:0] sh;
  logic [XLEN+1:0] tr;

  always_comb begin
    r  = rem_i;
    q  = quo_i;
    sh = '0;
    tr = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      sh = {r, q[XLEN-1]};
      q  = {q[XLEN-2:0], 1'b0};
      // trial subtract; the extra top bit is the borrow
      tr = sh - {2'b00, dvs_i};
      if (!tr[XLEN+1]) begin
        r    = tr[XLEN:0];
        q[0] = 1'b1;
      end else begin
        r = sh[XLEN:0];
      end
    end
    rem_o = r;
    quo_o = q;
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage RV32M unit; stalls decode->execute until result ready.
// Ports: clk, cpurst, md_kill, pipe_hold, md_busy, md (ex_muldiv_if.slave).
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN     = MD_XLEN,
  parameter int DIV_BITS = 1
)(
  input  logic         clk,
  input  logic         cpurst,
  input  logic         md_kill,
  input  logic         pipe_hold,
  output logic         md_busy,
  ex_muldiv_if.slave   md
);

  localparam int STEPS = XLEN / DIV_BITS;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e state_q, state_d;

  logic [2:0]      op_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic            sx1_q, sx2_q;
  logic [XLEN:0]   rem_q, rem_n;
  logic [XLEN-1:0] quo_q, quo_n;
  logic [XLEN-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] res_q;

  logic start;
  logic is_div, sgn_div, mulh1, mulh2;
  logic sx1_d, sx2_d;
  logic div_zero, div_ovf, div_fast;
  logic [XLEN-1:0] abs1, abs2, fast_res;

  assign start = md.md_req & ~md_kill;

  always_comb begin
    is_div  = 1'b0;
    sgn_div = 1'b0;
    mulh1   = 1'b0;
    mulh2   = 1'b0;
    unique case (1'b1)
      (md.md_op == MD_MULH): begin
        mulh1 = 1'b1;
        mulh2 = 1'b1;
      end
      (md.md_op == MD_MULHSU): mulh1 = 1'b1;
      (md.md_op == MD_DIV),
      (md.md_op == MD_REM): begin
        is_div  = 1'b1;
        sgn_div = 1'b1;
      end
      (md.md_op == MD_DIVU),
      (md.md_op == MD_REMU): is_div = 1'b1;
      default: ;
    endcase
  end

  // sign flags double as mul extension bits and div fixup flags
  assign sx1_d = (is_div ? sgn_div : mulh1) & md.md_rs1[XLEN-1];
  assign sx2_d = (is_div ? sgn_div : mulh2) & md.md_rs2[XLEN-1];
  assign abs1  = sx1_d ? -md.md_rs1 : md.md_rs1;
  assign abs2  = sx2_d ? -md.md_rs2 : md.md_rs2;

  assign div_zero = (md.md_rs2 == '0);
  assign div_ovf  = sgn_div & (md.md_rs1 == MIN_NEG)
                  & (md.md_rs2 == '1);
  assign div_fast = div_zero | div_ovf;

  // md_op[1] selects remainder for DIV*/REM* encodings
  always_comb begin
    fast_res = '0;
    if (md.md_op[1])
      fast_res = div_zero ? md.md_rs1 : '0;
    else
      fast_res = div_zero ? '1 : md.md_rs1;
  end

  // 33x33 signed product, carried at 2*XLEN so every bit is kept
  logic signed [2*XLEN-1:0] mul_a, mul_b, prod;
  assign mul_a = {{XLEN{sx1_q}}, rs1_q};
  assign mul_b = {{XLEN{sx2_q}}, rs2_q};
  assign prod  = mul_a * mul_b;

  md_div_step #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_n),
    .quo_o (quo_n)
  );

  logic [XLEN-1:0] quo_fix, rem_fix;
  assign quo_fix = (sx1_q ^ sx2_q) ? -quo_q : quo_q;
  assign rem_fix = sx1_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (cpurst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!is_div)       state_d = S_MUL;
          else if (div_fast) state_d = S_DONE;
          else               state_d = S_DIV;
        end
      end
      S_MUL:   state_d = S_DONE;
      S_DIV:   if (cnt_q == CNT_LAST) state_d = S_FIXUP;
      S_FIXUP: state_d = S_DONE;
      S_DONE:  if (!pipe_hold) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (md_kill) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (cpurst) begin
      op_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      sx1_q <= 1'b0;
      sx2_q <= 1'b0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else if (!md_kill) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q  <= md.md_op;
            rs1_q <= md.md_rs1;
            rs2_q <= md.md_rs2;
            sx1_q <= sx1_d;
            sx2_q <= sx2_d;
            rem_q <= '0;
            quo_q <= abs1;
            dvs_q <= abs2;
            cnt_q <= CNT_INIT;
            if (is_div && div_fast) res_q <= fast_res;
          end
        end
        S_MUL: begin
          if (op_q == MD_MUL) res_q <= prod[XLEN-1:0];
          else                res_q <= prod[2*XLEN-1:XLEN];
        end
        S_DIV: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q - CNT_LAST;
        end
        S_FIXUP: res_q <= op_q[1] ? rem_fix : quo_fix;
        default: ;
      endcase
    end
  end

  assign md.exe_stall = md.md_req & ~md_kill & ~cpurst
                      & (state_q != S_DONE);
  assign md.md_result_valid = (state_q == S_DONE) & ~md_kill;
  assign md.md_result = res_q;
  assign md_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: random + directed check of ex_muldiv against an arithmetic model.
// Drives the interface like the EX stage; checks result, stall count, hold, kill, reset.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam int DIV_BITS = 1;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic cpurst;
  logic md_kill;
  logic pipe_hold;
  logic md_busy;

  int total = 0;
  int bad = 0;

  ex_muldiv_if #(.XLEN(XLEN)) bus();

  ex_muldiv #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) dut (
    .clk       (clk),
    .cpurst    (cpurst),
    .md_kill   (md_kill),
    .pipe_hold (pipe_hold),
    .md_busy   (md_busy),
    .md        (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_stalls(input logic [2:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    if (op < 3'd4) return 2;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == MINV && b == 32'hFFFF_FFFF)
      return 1;
    return XLEN / DIV_BITS + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MINV;
      3: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold,
                        input bit b2b);
    logic [31:0] exp;
    int st;
    int n;
    exp = ref_md(op, a, b);
    bus.md_req = 1'b1;
    bus.md_op = op;
    bus.md_rs1 = a;
    bus.md_rs2 = b;
    pipe_hold = 1'b0;
    st = 0;
    n = 0;
    #1;
    while (bus.md_result_valid !== 1'b1 && n < 200) begin
      if (bus.exe_stall === 1'b1) st++;
      @(negedge clk);
      bus.md_rs1 = $urandom;
      bus.md_rs2 = $urandom;
      bus.md_op = 3'($urandom);
      #1;
      n++;
    end
    chk("done", {31'b0, bus.md_result_valid}, 32'd1);
    chk("result", bus.md_result, exp);
    chk("stalls", 32'(st), 32'(exp_stalls(op, a, b)));
    chk("done_stall", {31'b0, bus.exe_stall}, 32'd0);
    if (hold > 0) pipe_hold = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", {31'b0, bus.md_result_valid}, 32'd1);
      chk("hold_result", bus.md_result, exp);
      chk("hold_stall", {31'b0, bus.exe_stall}, 32'd0);
    end
    pipe_hold = 1'b0;
    @(negedge clk);
    if (!b2b) begin
      bus.md_req = 1'b0;
      #1;
      chk("left_valid", {31'b0, bus.md_result_valid}, 32'd0);
      chk("left_busy", {31'b0, md_busy}, 32'd0);
    end
  endtask

  initial begin
    logic [2:0] rop;
    logic [31:0] ra, rb;
    cpurst = 1'b1;
    md_kill = 1'b0;
    pipe_hold = 1'b0;
    bus.md_req = 1'b1;
    bus.md_op = 3'd4;
    bus.md_rs1 = 32'd9;
    bus.md_rs2 = 32'd3;
    @(negedge clk);
    #1;
    chk("rst_stall", {31'b0, bus.exe_stall}, 32'd0);
    chk("rst_valid", {31'b0, bus.md_result_valid}, 32'd0);
    chk("rst_result", bus.md_result, 32'd0);
    chk("rst_busy", {31'b0, md_busy}, 32'd0);
    cpurst = 1'b0;
    bus.md_req = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(3'd5, 32'd5, 32'd0, 0, 1'b0);
    run_op(3'd6, 32'd5, 32'd0, 0, 1'b0);
    run_op(3'd4, MINV, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'd7, 32'd100, 32'd9, 5, 1'b0);

    // kill in the 10th divide cycle
    bus.md_req = 1'b1;
    bus.md_op = 3'd5;
    bus.md_rs1 = 32'd1000;
    bus.md_rs2 = 32'd3;
    repeat (10) @(negedge clk);
    md_kill = 1'b1;
    #1;
    chk("kill_stall", {31'b0, bus.exe_stall}, 32'd0);
    chk("kill_valid", {31'b0, bus.md_result_valid}, 32'd0);
    @(negedge clk);
    md_kill = 1'b0;
    bus.md_req = 1'b0;
    #1;
    chk("kill_busy", {31'b0, md_busy}, 32'd0);
    chk("kill_nvalid", {31'b0, bus.md_result_valid}, 32'd0);
    run_op(3'd5, 32'd100, 32'd7, 0, 1'b0);

    run_op(3'd4, 32'd12345, 32'hFFFF_FFB3, 0, 1'b1);
    run_op(3'd0, 32'h0001_2345, 32'h0000_6789, 0, 1'b0);

    // reset in the middle of a divide
    bus.md_req = 1'b1;
    bus.md_op = 3'd4;
    bus.md_rs1 = 32'd999;
    bus.md_rs2 = 32'd5;
    repeat (15) @(negedge clk);
    cpurst = 1'b1;
    #1;
    chk("mrst_stall", {31'b0, bus.exe_stall}, 32'd0);
    @(negedge clk);
    cpurst = 1'b0;
    bus.md_req = 1'b0;
    #1;
    chk("mrst_busy", {31'b0, md_busy}, 32'd0);
    chk("mrst_valid", {31'b0, bus.md_result_valid}, 32'd0);
    chk("mrst_result", bus.md_result, 32'd0);
    run_op(3'd6, 32'hFFFF_FC19, 32'd5, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom);
      ra = pick();
      rb = pick();
      run_op(rop, ra, rb, $urandom_range(0, 3),
             (i < 59) && ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
